// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver/transmitter types, parity codes and bit-timing constant functions.
package uart_pkg;

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_t;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   function automatic int tick_div(input longint clk_hz, input longint baud, input longint ovr);
      longint d;
      d = clk_hz / (baud * ovr);
      return (d < 1) ? 1 : 32'(d);
   endfunction

   function automatic longint nco_inc(input longint clk_hz, input longint baud, input longint ovr,
                                      input int accw);
      return (((baud * ovr) << accw) + clk_hz / 2) / clk_hz;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick from an integer divider or a fractional NCO carry.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int USE_NCO    = 0,
   parameter int ACCW       = 32
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);

   generate
      if (USE_NCO != 0) begin : g_nco
         localparam logic [ACCW-1:0] INC = ACCW'(nco_inc(CLK_HZ, BAUD, OVERSAMPLE, ACCW));
         logic [ACCW-1:0] acc_q;
         logic            carry_q;
         always_ff @(posedge i_clk or negedge i_rst_n)
            if (!i_rst_n) {carry_q, acc_q} <= '0;
            else {carry_q, acc_q} <= {1'b0, acc_q} + {1'b0, INC};
         assign o_tick = carry_q;
      end else begin : g_div
         localparam int DIV = tick_div(CLK_HZ, BAUD, OVERSAMPLE);
         localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
         logic [W-1:0] cnt_q;
         always_ff @(posedge i_clk or negedge i_rst_n)
            if (!i_rst_n) cnt_q <= '0;
            else cnt_q <= (cnt_q == W'(DIV - 1)) ? '0 : cnt_q + W'(1);
         assign o_tick = (cnt_q == W'(DIV - 1));
      end
   endgenerate

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with a single-entry valid/ready output register.
// Define UART_RX_MAJORITY_EN to decide each bit by 2-of-3 majority around mid-bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int USE_NCO    = 0,
   parameter int ACCW       = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_overrun
);

   localparam int            PW        = $clog2(OVERSAMPLE);
   localparam int            BW        = $clog2(DATA_BITS + 1);
   localparam logic [PW-1:0] PH_MID    = PW'(OVERSAMPLE / 2 - 1);
   localparam logic [PW-1:0] PH_END    = PW'(OVERSAMPLE - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   logic                 ce_ovr, rx_s, dec, done, exp_par;
   logic [1:0]           sync_q;
   uart_state_t          state_q, state_d;
   logic                 armed_q, armed_d, perr_q, perr_d, ferr_q, ferr_d, stop_q, stop_d;
   logic [PW-1:0]        phase_q, phase_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d, data_q;
   logic                 valid_q, perr_o_q, ferr_o_q, ovr_q;

   uart_baud_tick #(
      .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE), .USE_NCO(USE_NCO), .ACCW(ACCW)
   ) u_tick (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .o_tick(ce_ovr)
   );

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) sync_q <= 2'b11;
      else sync_q <= {sync_q[0], i_rx};
   assign rx_s = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
   logic [1:0] hist_q;
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) hist_q <= 2'b11;
      else if (ce_ovr) hist_q <= {hist_q[0], rx_s};
   assign dec = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
`else
   assign dec = rx_s;
`endif

   assign exp_par = (PARITY == PARITY_ODD) ? ~^shift_q : ^shift_q;

   always_comb begin
      state_d = state_q;
      armed_d = armed_q;
      phase_d = phase_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      stop_d  = stop_q;
      done    = 1'b0;
      if (ce_ovr) begin
         phase_d = phase_q + PW'(1);
         case (state_q)
            ST_IDLE: begin
               phase_d = '0;
               if (rx_s) armed_d = 1'b1;
               else if (armed_q) begin
                  state_d = ST_START;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
                  stop_d  = 1'b0;
               end
            end
            ST_START:
               if (phase_q == PH_MID && dec) state_d = ST_IDLE;
               else if (phase_q == PH_END) begin
                  state_d = ST_DATA;
                  phase_d = '0;
                  bit_d   = '0;
               end
            ST_DATA: begin
               if (phase_q == PH_MID) shift_d = {dec, shift_q[DATA_BITS-1:1]};
               if (phase_q == PH_END) begin
                  phase_d = '0;
                  bit_d   = bit_q + BW'(1);
                  if (bit_q == BW'(DATA_BITS - 1))
                     state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (phase_q == PH_MID) perr_d = (dec != exp_par);
               if (phase_q == PH_END) begin
                  state_d = ST_STOP;
                  phase_d = '0;
               end
            end
            ST_STOP:
               // The last stop bit completes at mid-bit, leaving half a bit to resync on the next start.
               if (phase_q == PH_MID) begin
                  ferr_d = ferr_q | ~dec;
                  if (stop_q == LAST_STOP) begin
                     done    = 1'b1;
                     state_d = ST_IDLE;
                     armed_d = armed_q & ~ferr_d;
                  end
               end else if (phase_q == PH_END) begin
                  phase_d = '0;
                  stop_d  = 1'b1;
               end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
         phase_q <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= armed_d;
         phase_q <= phase_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
         stop_q  <= stop_d;
      end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         data_q   <= '0;
         valid_q  <= 1'b0;
         perr_o_q <= 1'b0;
         ferr_o_q <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         ovr_q <= done & valid_q & ~i_ready;
         if (done && (!valid_q || i_ready)) begin
            data_q   <= shift_q;
            perr_o_q <= perr_q;
            ferr_o_q <= ferr_d;
            valid_q  <= 1'b1;
         end else if (valid_q && i_ready) valid_q <= 1'b0;
      end

   assign o_data       = data_q;
   assign o_valid      = valid_q;
   assign o_parity_err = perr_o_q;
   assign o_frame_err  = ferr_o_q;
   assign o_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench driving an 8N1 and an 8E1 receiver with directed frames.
module tb_uart_rx;
   import uart_pkg::*;

   localparam int BAUD   = 115_200;
   localparam int OVR    = 16;
   localparam int CLK_HZ = BAUD * OVR * 4;
   localparam int BIT    = OVR * 4;

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b1, rdy1 = 1'b1;
   logic [7:0] d0, d1;
   logic       v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;
   logic [9:0] q0[$], q1[$];
   int         n_vec = 0, n_err = 0, ovr0 = 0, ovr1 = 0;

   always #5 clk = ~clk;

   uart_rx #(.DATA_BITS(8), .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVR), .PARITY(0),
             .STOP_BITS(1), .USE_NCO(0), .ACCW(32)) u0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx0), .o_data(d0), .o_valid(v0), .i_ready(rdy0),
      .o_parity_err(pe0), .o_frame_err(fe0), .o_overrun(ov0));

   uart_rx #(.DATA_BITS(8), .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OVR), .PARITY(1),
             .STOP_BITS(1), .USE_NCO(0), .ACCW(32)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx1), .o_data(d1), .o_valid(v1), .i_ready(rdy1),
      .o_parity_err(pe1), .o_frame_err(fe1), .o_overrun(ov1));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic setrx(input int ch, input logic v);
      if (ch == 0) rx0 = v;
      else rx1 = v;
   endtask

   // gbit selects a data bit that gets a one-tick inverted glitch at its centre (-1 for none)
   task automatic send(input int ch, input logic [7:0] d, input int pbit, input logic stop,
                       input int gbit);
      setrx(ch, 1'b0);
      clks(BIT);
      for (int i = 0; i < 8; i++) begin
         setrx(ch, d[i]);
         if (i == gbit) begin
            clks(BIT / 2 - 4);
            setrx(ch, ~d[i]);
            clks(4);
            setrx(ch, d[i]);
            clks(BIT / 2);
         end else clks(BIT);
      end
      if (pbit >= 0) begin
         setrx(ch, pbit[0]);
         clks(BIT);
      end
      setrx(ch, stop);
      clks(BIT);
   endtask

   task automatic drain(input string tag);
      int t = 0;
      while ((q0.size() != 0 || q1.size() != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(q0.size() + q1.size()), 0);
      clks(1);
   endtask

   always @(negedge clk) begin
      logic [9:0] e;
      if (ov0) ovr0++;
      if (v0 && rdy0) begin
         chk("u0 byte expected", 32'(q0.size() != 0), 1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("u0 data", d0, e[7:0]);
            chk("u0 parity_err", pe0, e[9]);
            chk("u0 frame_err", fe0, e[8]);
         end
      end
   end

   always @(negedge clk) begin
      logic [9:0] e;
      if (ov1) ovr1++;
      if (v1 && rdy1) begin
         chk("u1 byte expected", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("u1 data", d1, e[7:0]);
            chk("u1 parity_err", pe1, e[9]);
            chk("u1 frame_err", fe1, e[8]);
         end
      end
   end

   initial begin
      clks(5);
      chk("reset valid", v0, 0);
      chk("reset data", d0, 0);
      chk("reset parity_err", pe0, 0);
      chk("reset frame_err", fe0, 0);
      chk("reset overrun", ov0, 0);
      chk("reset valid u1", v1, 0);
      rst_n = 1'b1;
      clks(BIT);

      q0.push_back({2'b00, 8'hA5});
      send(0, 8'hA5, -1, 1'b1, -1);
      drain("8n1 a5");

      q1.push_back({2'b10, 8'h03});
      send(1, 8'h03, 1, 1'b1, -1);
      drain("bad parity");
      q1.push_back({2'b00, 8'h03});
      send(1, 8'h03, 0, 1'b1, -1);
      drain("good parity");

      q0.push_back({2'b01, 8'h5A});
      send(0, 8'h5A, -1, 1'b0, -1);
      clks(BIT * 10 * 3);
      setrx(0, 1'b1);
      clks(BIT * 2);
      drain("break");
      q0.push_back({2'b00, 8'h11});
      send(0, 8'h11, -1, 1'b1, -1);
      drain("after break");

      setrx(0, 1'b0);
      clks(8);
      setrx(0, 1'b1);
      clks(BIT * 2);
      chk("glitch state", 32'(u0.state_q), 32'(ST_IDLE));
      chk("glitch valid", v0, 0);

`ifdef UART_RX_MAJORITY_EN
      q0.push_back({2'b00, 8'h00});
      send(0, 8'h00, -1, 1'b1, 3);
      drain("majority");
`endif

      q0.push_back({2'b00, 8'h3C});
      q0.push_back({2'b00, 8'hC3});
      send(0, 8'h3C, -1, 1'b1, -1);
      send(0, 8'hC3, -1, 1'b1, -1);
      drain("back to back");

      rdy0 = 1'b0;
      q0.push_back({2'b00, 8'h01});
      send(0, 8'h01, -1, 1'b1, -1);
      send(0, 8'h02, -1, 1'b1, -1);
      clks(4);
      chk("overrun pulses", 32'(ovr0), 1);
      chk("overrun held data", d0, 8'h01);
      chk("overrun held valid", v0, 1);
      rdy0 = 1'b1;
      drain("overrun accept");
      clks(2);
      chk("valid after accept", v0, 0);

      rdy0 = 1'b0;
      send(0, 8'h42, -1, 1'b1, -1);
      clks(4);
      chk("pre-reset valid", v0, 1);
      fork
         send(0, 8'h77, -1, 1'b1, -1);
         begin
            clks(BIT * 5 + 10);
            rst_n = 1'b0;
            #1;
            chk("reset mid-frame valid", v0, 0);
            chk("reset mid-frame data", d0, 0);
         end
      join
      clks(BIT);
      rst_n = 1'b1;
      rdy0  = 1'b1;
      clks(BIT * 2);
      q0.push_back({2'b00, 8'hC3});
      send(0, 8'hC3, -1, 1'b1, -1);
      drain("after reset");

      chk("u1 overrun pulses", 32'(ovr1), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
